// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Contents:
//   - default data width and depth
//   - width helpers (pointer and occupancy count) derived from the depth
//   - read-mode selectors for the FWFT parameter
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Widths for the default geometry.
  localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

  // Read-mode selectors.
  localparam bit FWFT_OFF = 1'b0;  // registered read, one-cycle latency
  localparam bit FWFT_ON  = 1'b1;  // head word presented combinationally

  // Pointer width: indexes DEPTH entries and wraps naturally.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: needs one extra bit to represent the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W storage array.
// One synchronous write port and one asynchronous read port.
// Ports:
//   clk     - write clock
//   w_en    - write strobe (already qualified by the caller)
//   w_addr  - write address
//   w_data  - write data
//   r_addr  - read address
//   r_data  - read data, combinational from r_addr
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     w_en,
  input  logic [$clog2(DEPTH)-1:0] w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic [$clog2(DEPTH)-1:0] r_addr,
  output logic [DATA_W-1:0]        r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; occupancy and pointers decide
  // which words are valid, and a reset here would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and a
// selectable registered or first-word-fall-through read mode.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   w_en, w_data  - write request and data
//   r_en, r_data  - read request (pop in FWFT mode) and read data
//   full, empty, almost_full, almost_empty - status decoded from count
//   count         - occupancy, 0..DEPTH
//   overflow, underflow - sticky error flags
//   clr_err       - clears both error flags (a new error in the same cycle wins)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = FWFT_OFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [DATA_W-1:0]      w_data,
  input  logic                   r_en,
  output logic [DATA_W-1:0]      r_data,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem_rd;
  logic              wr_ok;
  logic              rd_ok;

  // Status comes only from the registered count, so accept decisions below
  // always see the flags as they were before the edge.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign wr_ok = w_en & ~full;
  assign rd_ok = r_en & ~empty;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (clk),
    .w_en   (wr_ok),
    .w_addr (wr_ptr),
    .w_data (w_data),
    .r_addr (rd_ptr),
    .r_data (mem_rd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;

      // Simultaneous accepted write and read leave the count unchanged.
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Setting has priority over clearing.
      if (w_en && full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;

      if (r_en && empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == FWFT_OFF) begin : g_reg_read
      // Registered read: data follows the accepted r_en by one cycle and
      // holds its value otherwise.
      always_ff @(posedge clk) begin
        if (rst)        r_data <= '0;
        else if (rd_ok) r_data <= mem_rd;
      end
    end else begin : g_fwft_read
      // Head word is presented directly; forced to zero while empty so stale
      // storage never leaks onto the bus.
      assign r_data = empty ? '0 : mem_rd;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the successor to the fixed 16x8 synchronous FIFO. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It also offers a selectable read mode: registered read or first-word-fall-through (FWFT). It sits between any producer and consumer in one clock domain and replaces the fixed FIFO wherever flow control or error visibility is needed.

## Interface
- DATA_W, 8, data width in bits.
- DEPTH, 16, number of entries; power of 2, >= 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, selects the read mode: 0 = registered read, 1 = first-word-fall-through.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- w_en  in  1  write request.
- w_data  in  DATA_W  write data.
- r_en  in  1  read request (FWFT=1: pop).
- r_data  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a write attempted while full.
- underflow  out  1  sticky; set by a read attempted while empty.
- clr_err  in  1  clears overflow and underflow.

## Operation
- **Accept conditions:** wr_ok = w_en & !full; rd_ok = r_en & !empty. Both are evaluated on the flags registered before the edge.
- **Write:** on wr_ok, mem[wr_ptr] <= w_data and wr_ptr increments.
- **Read:** on rd_ok, rd_ptr increments.
- **Pointers:** $clog2(DEPTH) bits wide; they wrap naturally from DEPTH-1 to 0.
- **Count:** count <= count + wr_ok - rd_ok. It is registered and never exceeds DEPTH or goes below 0.
- **Status flags:** full, empty, almost_full and almost_empty are decoded combinationally from the registered count only.
- **Simultaneous w_en and r_en:**
  - 0 < count < DEPTH: both are accepted and count is unchanged.
  - Full: only the read is accepted; the write is dropped and overflow is set.
  - Empty: only the write is accepted; the read is rejected and underflow is set.
- **Error flags:** overflow is set on w_en & full; underflow is set on r_en & empty. clr_err clears both. If clr_err and a new error occur in the same cycle, the set wins.
- **FWFT=0:** on rd_ok, r_data <= mem[rd_ptr]. Otherwise r_data holds its last value.
- **FWFT=1:** r_data = mem[rd_ptr] when !empty, and 0 when empty. It is a combinational read; r_en consumes the presented word.
- **Reset:** takes priority over everything.
  - Pointers, count, overflow, underflow and r_data (FWFT=0) go to 0.
  - Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not cleared.
  - Any w_en/r_en in the reset cycle is ignored.

## Timing
- **Write to status:** a write accepted at edge N updates count and flags immediately after edge N.
- **FWFT=0 read latency:** with r_en high at edge N, r_data is valid after edge N (1-cycle latency).
- **FWFT=1 head visibility:** the first word written into an empty FIFO at edge N appears on r_data after edge N, with no r_en needed.
- **Throughput:** one write and one read per cycle, sustained.
- **Error flags:** overflow/underflow assert after the offending edge and stay high until clr_err or rst.

## Structure
- **Package fifo_pkg:**
  - clog2-based pointer and count width constants.
  - Default DATA_W/DEPTH.
  - Mode constants FWFT_OFF/FWFT_ON.
- **Sub-module fifo_mem_2p:**
  - DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
  - No reset on the storage.
  - FWFT=0 adds the r_data output register in the top level.
- **Top level:** pointers, count, flags and error logic.

## Test plan
1. **Reset:** hold w_en=1 and r_en=1 with rst high for 3 cycles -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, r_data=0x00.
2. **Fill, overflow, drain:**
   - Write 0x00..0x0F -> almost_full asserts at count=14; full asserts after the 16th write.
   - 17th write -> overflow=1 and count stays 16.
   - Read 16 times -> r_data=0x00..0x0F in order, each one cycle after its r_en; empty=1 at the end.
3. **Pointer wrap:** write 10, read 10, write 12 words 0xA0..0xAB, read 12 -> exact order preserved across the wrap; count ends at 0.
4. **Simultaneous access:**
   - At count=5, w_en=r_en=1 for 4 cycles -> count stays 5 and FIFO order is preserved.
   - At count=0, w_en=r_en=1 -> write accepted, underflow=1, count=1.
   - clr_err -> underflow=0.
5. **FWFT=1:**
   - Write 0xA5 into an empty FIFO -> r_data=0xA5 after that edge with r_en low.
   - r_en for one cycle -> empty=1 and r_data=0x00.
6. **Reset mid-operation:**
   - At count=9, assert rst for 1 cycle -> count=0, empty=1, r_data=0x00, flags cleared.
   - Then write 0x3C and read -> 0x3C.
